// File: rtl/result_register_c_pkg.sv
// Shared definitions for the matrix-multiply result side: controller states,
// run-length constant and the flat element index helper.
package result_register_c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   function automatic int run_last(input int md);
      return 3 * md - 2;
   endfunction

   function automatic int elem_idx(input int r, input int c, input int md);
      return r * md + c;
   endfunction

   localparam int MAX_DIM  = 2;
   // Last count value of a run; the operand feed counters stop on the same value.
   localparam int RUN_LAST = run_last(MAX_DIM);

endpackage

// File: rtl/result_acc_cell.sv
// One result matrix element: storage, accumulate adder with carry-out flag,
// and forcing to zero when the element lies outside the active dimensions.
module result_acc_cell #(
   parameter int BUS_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr_flag,
   input  logic                 i_cap,
   input  logic                 i_acc,
   input  logic                 i_in_range,
   input  logic [BUS_WIDTH-1:0] i_pe_res,
   output logic [BUS_WIDTH-1:0] o_res,
   output logic                 o_flag
);

   logic [BUS_WIDTH-1:0] r_res;
   logic                 r_flag;
   logic [BUS_WIDTH:0]   w_sum;

   assign w_sum = {1'b0, r_res} + {1'b0, i_pe_res};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_res  <= '0;
         r_flag <= 1'b0;
      end else if (i_cap) begin
         if (!i_in_range) begin
            r_res  <= '0;
            r_flag <= 1'b0;
         end else if (i_acc) begin
            r_res  <= w_sum[BUS_WIDTH-1:0];
            r_flag <= r_flag | w_sum[BUS_WIDTH];
         end else begin
            r_res  <= i_pe_res;
         end
      end else if (i_clr_flag) begin
         r_flag <= 1'b0;
      end
   end

   assign o_res  = r_res;
   assign o_flag = r_flag;

endmodule

// File: rtl/result_register_c.sv
// Result register bank: times a multiply run, captures/accumulates the array
// results into the element cells and serves registered element reads.
//
//   state      | meaning
//   ST_IDLE    | waiting for start_i; reads only
//   ST_RUN     | array computing, cnt counts to RUN_LAST
//   ST_CAPTURE | results written into cells on the exiting edge
//   ST_DONE    | done_o pulse, then back to idle
module result_register_c
   import result_register_c_pkg::*;
#(
   parameter  int BUS_WIDTH  = 16,
   parameter  int DATA_WIDTH = 8,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   localparam int ADDR_W     = $clog2(MAX_DIM * MAX_DIM)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 start_i,
   input  logic                                 acc_en_i,
   input  logic [1:0]                           n_i,
   input  logic [1:0]                           m_i,
   input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] pe_res_i,
   input  logic                                 rd_en_i,
   input  logic [ADDR_W-1:0]                    rd_addr_i,
   output logic [BUS_WIDTH-1:0]                 rd_data_o,
   output logic                                 rd_valid_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic [MAX_DIM*MAX_DIM-1:0]           flags_o
);

   localparam int                NUM_EL   = MAX_DIM * MAX_DIM;
   localparam int                LAST_CNT = run_last(MAX_DIM);
   localparam int                CNT_W    = $clog2(LAST_CNT + 1);
   localparam logic [ADDR_W:0]   NUM_EL_C = (ADDR_W + 1)'(NUM_EL);

   state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               w_start;
   logic               w_cap;
   logic               r_acc;
   logic [1:0]         r_n, r_m;
   logic               r_busy, r_done;
   logic [BUS_WIDTH-1:0] r_rd_data;
   logic               r_rd_valid;
   logic               w_addr_ok;
   logic [BUS_WIDTH-1:0] w_res [NUM_EL];
   logic [NUM_EL-1:0]  w_flags;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_acc   <= 1'b0;
         r_n     <= '0;
         r_m     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         // Status outputs come straight from the next state so they stay registered.
         r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_CAPTURE);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_start) begin
            r_acc <= acc_en_i;
            r_n   <= n_i;
            r_m   <= m_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_start     = 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LAST_CNT)) begin
               w_state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: w_state_nxt = ST_DONE;
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_cap = (r_state == ST_CAPTURE);

   for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
      for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
         localparam int IDX = elem_idx(r, c, MAX_DIM);
         result_acc_cell #(
            .BUS_WIDTH (BUS_WIDTH)
         ) u_cell (
            .i_clk      (clk_i),
            .i_rst      (rst_i),
            .i_clr_flag (w_start),
            .i_cap      (w_cap),
            .i_acc      (r_acc),
            .i_in_range ((r <= int'(r_n)) && (c <= int'(r_m))),
            .i_pe_res   (pe_res_i[IDX*BUS_WIDTH +: BUS_WIDTH]),
            .o_res      (w_res[IDX]),
            .o_flag     (w_flags[IDX])
         );
      end
   end

   assign w_addr_ok = ({1'b0, rd_addr_i} < NUM_EL_C);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en_i;
         if (rd_en_i) begin
            r_rd_data <= w_addr_ok ? w_res[rd_addr_i] : '0;
         end
      end
   end

   assign rd_data_o  = r_rd_data;
   assign rd_valid_o = r_rd_valid;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign flags_o    = w_flags;

endmodule
